encoder_onehot_reg: RTL and testbench

- Registered one-hot to binary encoder; the inverse of the register-file write-select decoder tree.
- Converts an N-bit select vector, such as a register-file write-enable word, back into a W-bit register index.
- Flags illegal (non-one-hot) inputs and keeps a saturating count of them.
- Uses valid/ready handshakes on both sides so it can sit between the decode stage and the register-file check/debug logic.

---
 rtl/encoder_onehot_reg_if.sv | 27 ++
 rtl/encoder_onehot_reg.sv | 82 ++++++++
 tb/tb_encoder_onehot_reg.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/encoder_onehot_reg_if.sv
// Handshake bundle for the registered one-hot encoder.
// master: producer/consumer side (drives onehot, in_valid, out_ready).
// slave : the encoder itself.
interface encoder_onehot_reg_if #(
    parameter int N  = 32,
    parameter int W  = $clog2(N),
    parameter int CW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  onehot;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  index;
    logic          err;
    logic [CW-1:0] err_count;

    modport master (
        output in_valid, onehot, out_ready,
        input  in_ready, out_valid, index, err, err_count
    );

    modport slave (
        input  in_valid, onehot, out_ready,
        output in_ready, out_valid, index, err, err_count
    );
endinterface

// File: rtl/encoder_onehot_reg.sv
// Registered one-hot to binary encoder with valid/ready on both sides.
// Non-one-hot inputs (zero or multiple bits) set err and bump a
// saturating error counter. Multi-bit inputs encode to the lowest set
// bit, or to the highest set bit when ENC_HIGH_PRIORITY_EN is defined.
// Single output register with pass-through backpressure: one result per
// cycle, replaced in place when the consumer drains and a new input
// arrives on the same edge.
module encoder_onehot_reg #(
    parameter int N  = 32,
    parameter int W  = $clog2(N),
    parameter int CW = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    encoder_onehot_reg_if.slave bus
);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic          vld_q;
    logic [W-1:0]  idx_q,  idx_d;
    logic          err_q,  err_d;
    logic [CW-1:0] cnt_q,  cnt_d;

    logic          acc;
    logic          zero_in;
    logic          multi_in;

    // Output register is free when empty or being drained this cycle.
    assign bus.in_ready = !vld_q || bus.out_ready;
    assign acc          = bus.in_valid && bus.in_ready;

    // A vector is legal only if nonzero and clearing its lowest set bit
    // leaves nothing behind.
    assign zero_in  = ~|bus.onehot;
    assign multi_in = |(bus.onehot & (bus.onehot - N'(1)));
    assign err_d    = zero_in || multi_in;

    // Priority encode; the loop direction picks which set bit wins
    // (the last assignment in loop order takes effect).
    always_comb begin
        idx_d = '0;
`ifdef ENC_HIGH_PRIORITY_EN
        for (int i = 0; i < N; i++) begin
            if (bus.onehot[i]) idx_d = W'(i);
        end
`else
        for (int i = N - 1; i >= 0; i--) begin
            if (bus.onehot[i]) idx_d = W'(i);
        end
`endif
    end

    // Error counter counts accepted illegal inputs and sticks at max.
    always_comb begin
        cnt_d = cnt_q;
        if (acc && err_d && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CW'(1);
    end

    // Output stage: load on accept, drop valid on drain, otherwise hold.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_q <= 1'b0;
            idx_q <= '0;
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (acc) begin
                vld_q <= 1'b1;
                idx_q <= idx_d;
                err_q <= err_d;
            end else if (vld_q && bus.out_ready) begin
                vld_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = vld_q;
    assign bus.index     = idx_q;
    assign bus.err       = err_q;
    assign bus.err_count = cnt_q;
endmodule

// File: tb/tb_encoder_onehot_reg.sv
// Self-checking bench for encoder_onehot_reg: directed scenarios plus a
// randomized run against a transaction-level reference (queue of
// expected results and a saturating error tally).
module tb_encoder_onehot_reg;
    localparam int N  = 32;
    localparam int W  = $clog2(N);
    localparam int CW = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    encoder_onehot_reg_if #(.N(N), .W(W), .CW(CW)) bus ();

    encoder_onehot_reg #(.N(N), .W(W), .CW(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct { int idx; bit e; } res_t;

    res_t exp_q[$];
    int   exp_cnt = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    // Reference encoding straight from the rules: count bits, pick position.
    function automatic res_t ref_enc(input logic [N-1:0] v);
        res_t r;
        r.idx = 0;
        r.e   = ($countones(v) != 1);
`ifdef ENC_HIGH_PRIORITY_EN
        for (int i = 0; i < N; i++) if (v[i]) r.idx = i;
`else
        for (int i = N - 1; i >= 0; i--) if (v[i]) r.idx = i;
`endif
        return r;
    endfunction

    task automatic set_in(input bit iv, input logic [N-1:0] oh, input bit ordy);
        bus.in_valid  = iv;
        bus.onehot    = oh;
        bus.out_ready = ordy;
        #1;
    endtask

    // Advance one clock and move the reference model along.
    task automatic tick();
        bit   acc, otx;
        res_t r;
        acc = reset_n && bus.in_valid && (exp_q.size() == 0 || bus.out_ready);
        otx = (exp_q.size() != 0) && bus.out_ready;
        r   = ref_enc(bus.onehot);
        @(posedge clk);
        #1;
        if (!reset_n) begin
            exp_q.delete();
            exp_cnt = 0;
        end else begin
            if (otx) void'(exp_q.pop_front());
            if (acc) begin
                exp_q.push_back(r);
                if (r.e && exp_cnt < CMAX) exp_cnt++;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        set_in(1'b1, 32'h0000_0008, 1'b1);
        tick();
        tick();
        n_chk++;
        if ({bus.out_valid, bus.index, bus.err, bus.err_count} !== {1'b0, W'(0), 1'b0, CW'(0)}) begin
            n_fail++;
            $display("FAIL reset_state: got ov=%0b idx=%0d err=%0b cnt=%0d want 0/0/0/0",
                     bus.out_valid, bus.index, bus.err, bus.err_count);
        end
        n_chk++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready);
        end
        reset_n = 1'b1;
        set_in(1'b1, 32'h0000_0008, 1'b1);
        tick();
        n_chk++;
        if ({bus.out_valid, bus.index, bus.err} !== {1'b1, W'(3), 1'b0}) begin
            n_fail++;
            $display("FAIL reset_first_accept: got ov=%0b idx=%0d err=%0b want 1/3/0",
                     bus.out_valid, bus.index, bus.err);
        end
        set_in(1'b0, '0, 1'b1);
        tick();
    endtask

    task automatic test_stream();
        logic [N-1:0] vec [3];
        int           want [3];
        vec[0] = 32'h0000_0001; want[0] = 0;
        vec[1] = 32'h8000_0000; want[1] = 31;
        vec[2] = 32'h0001_0000; want[2] = 16;
        for (int k = 0; k < 3; k++) begin
            set_in(1'b1, vec[k], 1'b1);
            n_chk++;
            if (bus.in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_in_ready[%0d]: got %0b want 1", k, bus.in_ready);
            end
            tick();
            n_chk++;
            if ({bus.out_valid, bus.index, bus.err} !== {1'b1, W'(want[k]), 1'b0}) begin
                n_fail++;
                $display("FAIL stream_out[%0d]: got ov=%0b idx=%0d err=%0b want 1/%0d/0",
                         k, bus.out_valid, bus.index, bus.err, want[k]);
            end
        end
        set_in(1'b0, '0, 1'b1);
        tick();
    endtask

    task automatic test_backpressure();
        set_in(1'b1, 32'h0000_0004, 1'b1);
        tick();
        for (int k = 0; k < 3; k++) begin
            set_in(1'b1, 32'h0000_0010, 1'b0);
            n_chk++;
            if (bus.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_in_ready[%0d]: got %0b want 0", k, bus.in_ready);
            end
            tick();
            n_chk++;
            if ({bus.out_valid, bus.index, bus.err} !== {1'b1, W'(2), 1'b0}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got ov=%0b idx=%0d err=%0b want 1/2/0",
                         k, bus.out_valid, bus.index, bus.err);
            end
        end
        set_in(1'b1, 32'h0000_0010, 1'b1);
        tick();
        n_chk++;
        if ({bus.out_valid, bus.index, bus.err} !== {1'b1, W'(4), 1'b0}) begin
            n_fail++;
            $display("FAIL bp_release: got ov=%0b idx=%0d err=%0b want 1/4/0",
                     bus.out_valid, bus.index, bus.err);
        end
        set_in(1'b0, '0, 1'b1);
        tick();
        n_chk++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_no_dup: got ov=%0b want 0", bus.out_valid);
        end
    endtask

    task automatic test_illegal();
        int hi_idx;
`ifdef ENC_HIGH_PRIORITY_EN
        hi_idx = 5;
`else
        hi_idx = 4;
`endif
        set_in(1'b1, '0, 1'b1);
        tick();
        n_chk++;
        if ({bus.out_valid, bus.index, bus.err, bus.err_count} !== {1'b1, W'(0), 1'b1, CW'(1)}) begin
            n_fail++;
            $display("FAIL illegal_zero: got ov=%0b idx=%0d err=%0b cnt=%0d want 1/0/1/1",
                     bus.out_valid, bus.index, bus.err, bus.err_count);
        end
        set_in(1'b1, 32'h0000_0030, 1'b1);
        tick();
        n_chk++;
        if ({bus.out_valid, bus.index, bus.err, bus.err_count} !== {1'b1, W'(hi_idx), 1'b1, CW'(2)}) begin
            n_fail++;
            $display("FAIL illegal_multi: got ov=%0b idx=%0d err=%0b cnt=%0d want 1/%0d/1/2",
                     bus.out_valid, bus.index, bus.err, bus.err_count, hi_idx);
        end
        set_in(1'b0, '0, 1'b1);
        tick();
        n_chk++;
        if ({bus.out_valid, bus.err_count} !== {1'b0, CW'(2)}) begin
            n_fail++;
            $display("FAIL illegal_cnt_kept: got ov=%0b cnt=%0d want 0/2",
                     bus.out_valid, bus.err_count);
        end
    endtask

    task automatic test_saturation();
        int want;
        reset_n = 1'b0;
        set_in(1'b0, '0, 1'b1);
        tick();
        reset_n = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            set_in(1'b1, '0, 1'b1);
            tick();
            want = (k < CMAX) ? k : CMAX;
            n_chk++;
            if ({bus.out_valid, bus.err, bus.err_count} !== {1'b1, 1'b1, CW'(want)}) begin
                n_fail++;
                $display("FAIL sat_count[%0d]: got ov=%0b err=%0b cnt=%0d want 1/1/%0d",
                         k, bus.out_valid, bus.err, bus.err_count, want);
            end
        end
        set_in(1'b1, 32'h0000_0100, 1'b1);
        tick();
        n_chk++;
        if ({bus.out_valid, bus.index, bus.err, bus.err_count} !== {1'b1, W'(8), 1'b0, CW'(CMAX)}) begin
            n_fail++;
            $display("FAIL sat_legal_after: got ov=%0b idx=%0d err=%0b cnt=%0d want 1/8/0/255",
                     bus.out_valid, bus.index, bus.err, bus.err_count);
        end
        set_in(1'b0, '0, 1'b1);
        tick();
    endtask

    task automatic test_mid_reset();
        set_in(1'b1, '0, 1'b1);
        tick();
        set_in(1'b1, 32'h0000_0080, 1'b1);
        tick();
        set_in(1'b1, 32'h0000_0002, 1'b0);
        tick();
        n_chk++;
        if ({bus.out_valid, bus.index, bus.err} !== {1'b1, W'(7), 1'b0}) begin
            n_fail++;
            $display("FAIL midrst_stall: got ov=%0b idx=%0d err=%0b want 1/7/0",
                     bus.out_valid, bus.index, bus.err);
        end
        reset_n = 1'b0;
        set_in(1'b1, 32'h0000_0002, 1'b1);
        tick();
        n_chk++;
        if ({bus.out_valid, bus.err_count} !== {1'b0, CW'(0)}) begin
            n_fail++;
            $display("FAIL midrst_clear: got ov=%0b cnt=%0d want 0/0",
                     bus.out_valid, bus.err_count);
        end
        reset_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            set_in(1'b0, '0, 1'b1);
            tick();
            n_chk++;
            if (bus.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_no_stale[%0d]: got ov=%0b want 0", k, bus.out_valid);
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] v;
        int           sel;
        for (int c = 0; c < 600; c++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       v = '0;
                1:       v = N'(1) << $urandom_range(0, N - 1);
                2:       v = N'($urandom);
                default: v = (N'(1) << $urandom_range(0, N - 1)) | (N'(1) << $urandom_range(0, N - 1));
            endcase
            reset_n = ($urandom_range(0, 99) != 0);
            set_in($urandom_range(0, 3) != 0, v, $urandom_range(0, 2) != 0);
            n_chk++;
            if (bus.in_ready !== (exp_q.size() == 0 || bus.out_ready)) begin
                n_fail++;
                $display("FAIL rand_in_ready[%0d]: got %0b want %0b",
                         c, bus.in_ready, (exp_q.size() == 0 || bus.out_ready));
            end
            if (exp_q.size() != 0) begin
                n_chk++;
                if ({bus.index, bus.err} !== {W'(exp_q[0].idx), exp_q[0].e}) begin
                    n_fail++;
                    $display("FAIL rand_result[%0d]: got idx=%0d err=%0b want idx=%0d err=%0b",
                             c, bus.index, bus.err, exp_q[0].idx, exp_q[0].e);
                end
            end
            tick();
            n_chk++;
            if ({bus.out_valid, bus.err_count} !== {exp_q.size() != 0, CW'(exp_cnt)}) begin
                n_fail++;
                $display("FAIL rand_state[%0d]: got ov=%0b cnt=%0d want ov=%0b cnt=%0d",
                         c, bus.out_valid, bus.err_count, exp_q.size() != 0, exp_cnt);
            end
        end
        reset_n = 1'b1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.onehot    = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_illegal();
        test_saturation();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
